// File: rtl/add_and_or_unit.sv
// add_and_or_unit: registered 64-bit ADD/AND/OR execute-stage unit with status flags.
//
// Operands and op are sampled on a rising clock edge when in_valid is high; the
// result and flags appear after that edge and out_valid pulses for one cycle.
// When in_valid is low, rd and the flags hold their values and out_valid drops.
//
// Ports:
//   clk       - clock, all state on rising edge
//   rst       - synchronous active-high reset, clears all outputs
//   in_valid  - op/rs1/rs2/cin valid this cycle
//   op        - 00 AND, 01 OR, 10 ADD, 11 invalid
//   rs1, rs2  - operands (two's complement)
//   cin       - carry-in, used by ADD only
//   rd        - registered result
//   zero      - rd == 0 (forced 0 for invalid op)
//   carry     - unsigned carry-out of ADD
//   overflow  - signed overflow of ADD
//   illegal   - op was 11
//   out_valid - rd and flags hold a new result

module add_and_or_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             cin,
    output logic [WIDTH-1:0] rd,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal,
    output logic             out_valid
);

    localparam logic [1:0] OpAnd = 2'b00;
    localparam logic [1:0] OpOr  = 2'b01;
    localparam logic [1:0] OpAdd = 2'b10;

    // Operands are zero-padded up to a whole number of 4-bit groups so that
    // any WIDTH >= 4 works; padding bits have g = p = 0.
    localparam int unsigned NumGroups = (WIDTH + 3) / 4;
    localparam int unsigned PadWidth  = NumGroups * 4;

    logic [PadWidth-1:0] a_pad;
    logic [PadWidth-1:0] b_pad;
    logic [PadWidth-1:0] gen;
    logic [PadWidth-1:0] prop;
    logic [PadWidth:0]   c;
    logic [PadWidth-1:0] sum;

    always_comb begin
        a_pad              = '0;
        b_pad              = '0;
        a_pad[WIDTH-1:0]   = rs1;
        b_pad[WIDTH-1:0]   = rs2;
    end

    assign gen  = a_pad & b_pad;
    assign prop = a_pad ^ b_pad;
    assign c[0] = cin;

    // Each group computes its internal carries and carry-out directly from the
    // group carry-in (lookahead); group carries ripple from group to group.
    for (genvar k = 0; k < NumGroups; k++) begin : g_cla
        localparam int unsigned B = k * 4;
        logic ci;
        logic [3:0] g;
        logic [3:0] p;

        assign ci = c[B];
        assign g  = gen[B+3:B];
        assign p  = prop[B+3:B];

        assign c[B+1] = g[0] | (p[0] & ci);
        assign c[B+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        assign c[B+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                      | (p[2] & p[1] & p[0] & ci);
        assign c[B+4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                      | (p[3] & p[2] & p[1] & g[0])
                      | (p[3] & p[2] & p[1] & p[0] & ci);
    end

    assign sum = prop ^ c[PadWidth-1:0];

    logic [WIDTH-1:0] rd_d;
    logic             zero_d;
    logic             carry_d;
    logic             overflow_d;
    logic             illegal_d;

    always_comb begin
        rd_d       = '0;
        zero_d     = 1'b0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        illegal_d  = 1'b0;
        unique case (op)
            OpAnd: begin
                rd_d   = rs1 & rs2;
                zero_d = (rd_d == '0);
            end
            OpOr: begin
                rd_d   = rs1 | rs2;
                zero_d = (rd_d == '0);
            end
            OpAdd: begin
                rd_d       = sum[WIDTH-1:0];
                zero_d     = (rd_d == '0);
                // Carry into the first bit above the real operand width.
                carry_d    = c[WIDTH];
                overflow_d = (rs1[WIDTH-1] == rs2[WIDTH-1]) &&
                             (rd_d[WIDTH-1] != rs1[WIDTH-1]);
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    logic [WIDTH-1:0] rd_q;
    logic             zero_q;
    logic             carry_q;
    logic             overflow_q;
    logic             illegal_q;
    logic             out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q        <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                rd_q       <= rd_d;
                zero_q     <= zero_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
                illegal_q  <= illegal_d;
            end
        end
    end

    assign rd        = rd_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_and_or_unit.sv
// tb_add_and_or_unit: directed self-checking bench for add_and_or_unit.
// Observed vector is {rd, zero, carry, overflow, illegal, out_valid}.

module tb_add_and_or_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        cin;
    logic [63:0] rd;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        illegal;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    logic [68:0] obs;
    assign obs = {rd, zero, carry, overflow, illegal, out_valid};

    add_and_or_unit #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .cin       (cin),
        .rd        (rd),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's worth of inputs on the falling edge, then step past the
    // next rising edge so outputs can be sampled.
    task automatic step(input logic r, input logic v, input logic [1:0] o,
                        input logic [63:0] a, input logic [63:0] b, input logic ci);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        op       = o;
        rs1      = a;
        rs2      = b;
        cin      = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 2'b10, 64'd5, 64'd7, 1'b0);
            checks++;
            if (obs !== {64'd0, 5'b00000}) begin
                errors++;
                $display("FAIL reset_hold[%0d] got %h want %h", i, obs, {64'd0, 5'b00000});
            end
        end
        step(1'b0, 1'b1, 2'b00, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F, 1'b0);
        checks++;
        if (obs !== {64'h00F0_0000_0000_000F, 5'b00001}) begin
            errors++;
            $display("FAIL reset_release got %h want %h", obs,
                     {64'h00F0_0000_0000_000F, 5'b00001});
        end
    endtask

    task automatic test_logic;
        step(1'b0, 1'b1, 2'b00, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
        checks++;
        if (obs !== {64'd0, 5'b10001}) begin
            errors++;
            $display("FAIL and_zero got %h want %h", obs, {64'd0, 5'b10001});
        end
        step(1'b0, 1'b1, 2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
        checks++;
        if (obs !== {64'hFFFF_FFFF_FFFF_FFFF, 5'b00001}) begin
            errors++;
            $display("FAIL or_ones got %h want %h", obs, {64'hFFFF_FFFF_FFFF_FFFF, 5'b00001});
        end
        step(1'b0, 1'b1, 2'b01, 64'h1200_0000_0000_0030, 64'h0034_0000_0000_0005, 1'b0);
        checks++;
        if (obs !== {64'h1234_0000_0000_0035, 5'b00001}) begin
            errors++;
            $display("FAIL or_mixed got %h want %h", obs, {64'h1234_0000_0000_0035, 5'b00001});
        end
    endtask

    task automatic test_add_carry;
        step(1'b0, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        checks++;
        if (obs !== {64'd0, 5'b11001}) begin
            errors++;
            $display("FAIL add_wrap got %h want %h", obs, {64'd0, 5'b11001});
        end
        step(1'b0, 1'b1, 2'b10, 64'd5, 64'd7, 1'b1);
        checks++;
        if (obs !== {64'd13, 5'b00001}) begin
            errors++;
            $display("FAIL add_cin got %h want %h", obs, {64'd13, 5'b00001});
        end
        step(1'b0, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        checks++;
        if (obs !== {64'd0, 5'b11001}) begin
            errors++;
            $display("FAIL add_cin_chain got %h want %h", obs, {64'd0, 5'b11001});
        end
        step(1'b0, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        checks++;
        if (obs !== {64'hFFFF_FFFF_FFFF_FFFE, 5'b01001}) begin
            errors++;
            $display("FAIL add_neg_neg got %h want %h", obs,
                     {64'hFFFF_FFFF_FFFF_FFFE, 5'b01001});
        end
        step(1'b0, 1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
        checks++;
        if (obs !== {64'h1234_5678_9ABC_DF00, 5'b00001}) begin
            errors++;
            $display("FAIL add_mixed got %h want %h", obs, {64'h1234_5678_9ABC_DF00, 5'b00001});
        end
    endtask

    task automatic test_add_overflow;
        step(1'b0, 1'b1, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        checks++;
        if (obs !== {64'h8000_0000_0000_0000, 5'b00101}) begin
            errors++;
            $display("FAIL add_pos_ovf got %h want %h", obs, {64'h8000_0000_0000_0000, 5'b00101});
        end
        step(1'b0, 1'b1, 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        checks++;
        if (obs !== {64'd0, 5'b11101}) begin
            errors++;
            $display("FAIL add_neg_ovf got %h want %h", obs, {64'd0, 5'b11101});
        end
    endtask

    task automatic test_back_to_back;
        step(1'b0, 1'b1, 2'b10, 64'd100, 64'd23, 1'b0);
        checks++;
        if (obs !== {64'd123, 5'b00001}) begin
            errors++;
            $display("FAIL b2b_add got %h want %h", obs, {64'd123, 5'b00001});
        end
        step(1'b0, 1'b1, 2'b00, 64'h0000_0000_0000_FF0F, 64'h0000_0000_0000_0FF0, 1'b0);
        checks++;
        if (obs !== {64'h0000_0000_0000_0F00, 5'b00001}) begin
            errors++;
            $display("FAIL b2b_and got %h want %h", obs, {64'h0000_0000_0000_0F00, 5'b00001});
        end
        step(1'b0, 1'b1, 2'b01, 64'hDEAD_0000_0000_0000, 64'h0000_0000_0000_BEEF, 1'b0);
        checks++;
        if (obs !== {64'hDEAD_0000_0000_BEEF, 5'b00001}) begin
            errors++;
            $display("FAIL b2b_or got %h want %h", obs, {64'hDEAD_0000_0000_BEEF, 5'b00001});
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
            checks++;
            if (obs !== {64'hDEAD_0000_0000_BEEF, 5'b00000}) begin
                errors++;
                $display("FAIL hold[%0d] got %h want %h", i, obs,
                         {64'hDEAD_0000_0000_BEEF, 5'b00000});
            end
        end
    endtask

    task automatic test_illegal_and_reset;
        // Flags set by the previous op must hold across an idle cycle.
        step(1'b0, 1'b1, 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        step(1'b0, 1'b0, 2'b11, 64'd0, 64'd0, 1'b0);
        checks++;
        if (obs !== {64'd0, 5'b11100}) begin
            errors++;
            $display("FAIL hold_flags got %h want %h", obs, {64'd0, 5'b11100});
        end
        step(1'b0, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        checks++;
        if (obs !== {64'd0, 5'b00011}) begin
            errors++;
            $display("FAIL illegal_op got %h want %h", obs, {64'd0, 5'b00011});
        end
        step(1'b0, 1'b1, 2'b10, 64'd5, 64'd7, 1'b0);
        checks++;
        if (obs !== {64'd12, 5'b00001}) begin
            errors++;
            $display("FAIL illegal_clear got %h want %h", obs, {64'd12, 5'b00001});
        end
        step(1'b1, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        checks++;
        if (obs !== {64'd0, 5'b00000}) begin
            errors++;
            $display("FAIL mid_reset got %h want %h", obs, {64'd0, 5'b00000});
        end
        step(1'b0, 1'b0, 2'b10, 64'd1, 64'd1, 1'b0);
        checks++;
        if (obs !== {64'd0, 5'b00000}) begin
            errors++;
            $display("FAIL post_reset_idle got %h want %h", obs, {64'd0, 5'b00000});
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 2'b00;
        rs1      = '0;
        rs2      = '0;
        cin      = 1'b0;
        test_reset();
        test_logic();
        test_add_carry();
        test_add_overflow();
        test_back_to_back();
        test_illegal_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_and_or_unit.md
# add_and_or_unit

Registered 64-bit execute-stage unit implementing the ADD, AND and OR operations of the RV64 ALU, with zero, carry and overflow status flags. It sits between the operand-select logic and the ALU result mux. Operands are sampled on one clock edge and the result and flags are presented on the next.

## Interface
Parameters:
- `WIDTH`, default 64: operand and result width. All behaviour below is stated for 64; it must generalise to any `WIDTH` ≥ 4.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: operands and `op` are valid this cycle.
- `op`, input, 2: operation select.
  - 00 = AND
  - 01 = OR
  - 10 = ADD
  - 11 = invalid
- `rs1`, input, WIDTH: operand A, two's-complement.
- `rs2`, input, WIDTH: operand B, two's-complement.
- `cin`, input, 1: carry-in. Used by ADD only; the ALU ties it to 0.
- `rd`, output, WIDTH: registered result.
- `zero`, output, 1: registered flag; `rd` == 0.
- `carry`, output, 1: registered unsigned carry-out.
- `overflow`, output, 1: registered signed-overflow flag.
- `illegal`, output, 1: registered flag; `op` was 11.
- `out_valid`, output, 1: `rd` and the flags hold a new result.

## Operation
- AND: `rd` = `rs1` & `rs2`, bitwise. `carry` = 0, `overflow` = 0.
- OR: `rd` = `rs1` | `rs2`, bitwise. `carry` = 0, `overflow` = 0.
- ADD: full sum S = `rs1` + `rs2` + `cin`, computed at WIDTH+1 bits unsigned.
  - `rd` = S[WIDTH-1:0].
  - `carry` = S[WIDTH], i.e. the unsigned result lies outside [0, 2^WIDTH−1].
  - `overflow` = (`rs1`[MSB] == `rs2`[MSB]) && (`rd`[MSB] != `rs1`[MSB]), i.e. the signed result lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Adder structure: 4-bit carry-lookahead groups with rippled group carries. Must be purely combinational ahead of the output register.
- `zero` = (`rd` == 0) for every legal op, ADD included. Example: ADD producing a wrapped result of 0 sets both `zero` and `carry`.
- Invalid op (11):
  - `rd` = 0, `zero` = 0, `carry` = 0, `overflow` = 0, `illegal` = 1.
  - `out_valid` still asserts, so the pipeline never stalls.
- `illegal` = 0 for every legal op.

## Timing
- Latency is 1 cycle. If `in_valid` = 1 at rising edge N, `rd` and all flags reflect those inputs after edge N, and `out_valid` = 1 for exactly that cycle.
- Back-to-back issue: `in_valid` high on consecutive edges gives one result per cycle. There are no bubbles and no backpressure.
- `in_valid` = 0 at an edge: `out_valid` goes to 0; `rd` and all flags hold their previous values.
- Reset: `rst` = 1 at an edge forces `rd` = 0, `zero` = 0, `carry` = 0, `overflow` = 0, `illegal` = 0 and `out_valid` = 0.
  - Reset overrides a simultaneous `in_valid`; that operation is discarded.
  - The first result after reset requires `rst` = 0 and `in_valid` = 1 at the same edge.
- Inputs are don't-care while `in_valid` = 0.
- No output is combinationally dependent on any input.

## Test plan
- Reset: hold `rst` high 2 cycles with `in_valid` = 1 → all outputs 0 and `out_valid` = 0. Release `rst` → the next valid op appears 1 cycle later.
- Logic ops: AND `0xF0F0_0000_0000_00FF` & `0x0FF0_0000_0000_0F0F` → `rd` = `0x00F0_0000_0000_000F`, `zero` = 0. AND `0xAAAA…` & `0x5555…` → `rd` = 0, `zero` = 1. OR of the same pair → `rd` = `0xFFFF…`, `carry` = 0, `overflow` = 0.
- ADD carry/zero: `0xFFFF_FFFF_FFFF_FFFF` + 1, `cin` = 0 → `rd` = 0, `zero` = 1, `carry` = 1, `overflow` = 0. Also 5 + 7 with `cin` = 1 → `rd` = 13, all flags 0.
- ADD signed overflow: `0x7FFF_FFFF_FFFF_FFFF` + 1 → `rd` = `0x8000_0000_0000_0000`, `overflow` = 1, `carry` = 0. Also `0x8000…0` + `0x8000…0` → `rd` = 0, `overflow` = 1, `carry` = 1, `zero` = 1.
- Pipeline/hold: issue ADD, AND, OR on 3 consecutive edges, then drop `in_valid` → 3 consecutive `out_valid` pulses with matching results. `rd` then holds the OR result while `out_valid` = 0.
- Invalid op and mid-stream reset: `op` = 11 → `illegal` = 1, `rd` = 0, `out_valid` = 1. Assert `rst` on the same edge as a valid ADD → outputs cleared and no `out_valid` pulse.
